// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - central pipeline sequencer: hazards, memory freeze, watchdog, perf counters
module pipeline_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [4:0]       ID_RS1addr_i,
    input  logic [4:0]       ID_RS2addr_i,
    input  logic             EX_MemRead_i,
    input  logic [4:0]       EX_RDaddr_i,
    input  logic             ID_BranchTaken_i,
    input  logic             MEM_Req_i,
    input  logic             MEM_Ready_i,
    output logic             PCWrite_o,
    output logic             IF_ID_Write_o,
    output logic             IF_ID_Flush_o,
    output logic             ID_EX_Write_o,
    output logic             ID_EX_NoOp_o,
    output logic             EX_MEM_Write_o,
    output logic             MEM_WB_NoOp_o,
    output logic [1:0]       state_o,
    output logic             error_o,
    output logic [CNT_W-1:0] cycle_cnt_o,
    output logic [CNT_W-1:0] stall_cnt_o,
    output logic [CNT_W-1:0] flush_cnt_o
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_MEM_WAIT = 2'd2,
        S_HALT     = 2'd3
    } state_t;

    // Output pattern selected each cycle; decouples state decisions from pin encoding.
    typedef enum logic [2:0] {
        M_IDLE,
        M_FREEZE,
        M_LOAD_USE,
        M_BRANCH,
        M_NORMAL,
        M_HALT
    } mode_t;

    localparam logic [15:0] WD_LIMIT = 16'(MEM_TIMEOUT);

    state_t      state_q, state_d;
    mode_t       mode;
    mode_t       adv_mode;
    logic [15:0] wd_q, wd_d;
    logic        err_q, err_set;
    logic        load_use;
    logic        freeze;
    logic        active;

    logic [CNT_W-1:0] cycle_q, stall_q, flush_q;

    assign load_use = EX_MemRead_i && (EX_RDaddr_i != 5'd0) &&
                      ((EX_RDaddr_i == ID_RS1addr_i) || (EX_RDaddr_i == ID_RS2addr_i));
    assign freeze   = MEM_Req_i && !MEM_Ready_i;

    // Pattern used whenever the pipe is allowed to advance: load-use beats branch.
    assign adv_mode = load_use         ? M_LOAD_USE :
                      ID_BranchTaken_i ? M_BRANCH   : M_NORMAL;

    // State register, watchdog and sticky error.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= S_IDLE;
            wd_q    <= 16'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wd_q    <= wd_d;
            err_q   <= err_q | err_set;
        end
    end

    // Next-state, watchdog update and output-pattern selection.
    always_comb begin
        state_d = state_q;
        wd_d    = wd_q;
        err_set = 1'b0;
        mode    = M_IDLE;
        case (state_q)
            S_IDLE: begin
                mode = M_IDLE;
                wd_d = 16'd0;
                if (start_i) state_d = S_RUN;
            end
            S_RUN: begin
                if (freeze) begin
                    mode    = M_FREEZE;
                    state_d = S_MEM_WAIT;
                    wd_d    = 16'd1;
                end else begin
                    mode = adv_mode;
                    if (!start_i) state_d = S_IDLE;
                end
            end
            S_MEM_WAIT: begin
                if (!MEM_Ready_i) begin
                    mode = M_FREEZE;
                    if (wd_q == WD_LIMIT) begin
                        state_d = S_HALT;
                        err_set = 1'b1;
                    end else begin
                        wd_d = wd_q + 16'd1;
                    end
                end else begin
                    mode    = adv_mode;
                    state_d = S_RUN;
                    wd_d    = 16'd0;
                end
            end
            default: begin
                mode = M_HALT;
            end
        endcase
    end

    // Decode the selected pattern onto the pipeline control pins.
    always_comb begin
        PCWrite_o      = 1'b0;
        IF_ID_Write_o  = 1'b0;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Write_o  = 1'b0;
        ID_EX_NoOp_o   = 1'b0;
        EX_MEM_Write_o = 1'b0;
        MEM_WB_NoOp_o  = 1'b0;
        case (mode)
            M_IDLE, M_LOAD_USE: begin
                ID_EX_Write_o  = 1'b1;
                ID_EX_NoOp_o   = 1'b1;
                EX_MEM_Write_o = 1'b1;
            end
            M_FREEZE: begin
                MEM_WB_NoOp_o  = 1'b1;
            end
            M_BRANCH: begin
                PCWrite_o      = 1'b1;
                IF_ID_Write_o  = 1'b1;
                IF_ID_Flush_o  = 1'b1;
                ID_EX_Write_o  = 1'b1;
                EX_MEM_Write_o = 1'b1;
            end
            M_NORMAL: begin
                PCWrite_o      = 1'b1;
                IF_ID_Write_o  = 1'b1;
                ID_EX_Write_o  = 1'b1;
                EX_MEM_Write_o = 1'b1;
            end
            default: begin
                ID_EX_NoOp_o   = 1'b1;
                MEM_WB_NoOp_o  = 1'b1;
            end
        endcase
    end

    assign active = (state_q == S_RUN) || (state_q == S_MEM_WAIT);

    // Saturating performance counters; they stick at all-ones instead of wrapping.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cycle_q <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (active && (cycle_q != '1))
                cycle_q <= cycle_q + CNT_W'(1);
            if (active && !PCWrite_o && (stall_q != '1))
                stall_q <= stall_q + CNT_W'(1);
            if (IF_ID_Flush_o && (flush_q != '1))
                flush_q <= flush_q + CNT_W'(1);
        end
    end

    assign state_o     = state_q;
    assign error_o     = err_q;
    assign cycle_cnt_o = cycle_q;
    assign stall_cnt_o = stall_q;
    assign flush_cnt_o = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;

    localparam int CW = 4;

    // {PCWrite, IF_ID_Write, IF_ID_Flush, ID_EX_Write, ID_EX_NoOp, EX_MEM_Write, MEM_WB_NoOp}
    localparam logic [6:0] C_IDLE = 7'b0001110;
    localparam logic [6:0] C_LU   = 7'b0001110;
    localparam logic [6:0] C_NORM = 7'b1101010;
    localparam logic [6:0] C_BR   = 7'b1111010;
    localparam logic [6:0] C_FZ   = 7'b0000001;
    localparam logic [6:0] C_HALT = 7'b0000101;

    typedef struct packed {
        logic       start;
        logic       mr;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       br;
        logic       req;
        logic       rdy;
    } stim_t;

    typedef struct packed {
        logic [6:0] ctrl;
        logic [1:0] st;
    } exp_t;

    logic          clk, rst_n, start;
    logic [4:0]    rs1, rs2, rd;
    logic          mem_read, br_taken, mem_req, mem_rdy;
    logic          pc_w, ifid_w, ifid_f, idex_w, idex_n, exmem_w, memwb_n;
    logic [1:0]    state;
    logic          err;
    logic [CW-1:0] cyc_cnt, stl_cnt, fl_cnt;
    logic [6:0]    ctrl;

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(CW)) dut (
        .clk_i(clk), .rst_i(rst_n), .start_i(start),
        .ID_RS1addr_i(rs1), .ID_RS2addr_i(rs2),
        .EX_MemRead_i(mem_read), .EX_RDaddr_i(rd),
        .ID_BranchTaken_i(br_taken), .MEM_Req_i(mem_req), .MEM_Ready_i(mem_rdy),
        .PCWrite_o(pc_w), .IF_ID_Write_o(ifid_w), .IF_ID_Flush_o(ifid_f),
        .ID_EX_Write_o(idex_w), .ID_EX_NoOp_o(idex_n), .EX_MEM_Write_o(exmem_w),
        .MEM_WB_NoOp_o(memwb_n), .state_o(state), .error_o(err),
        .cycle_cnt_o(cyc_cnt), .stall_cnt_o(stl_cnt), .flush_cnt_o(fl_cnt)
    );

    assign ctrl = {pc_w, ifid_w, ifid_f, idex_w, idex_n, exmem_w, memwb_n};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic stim_t mk(logic s, logic m, logic [4:0] d, logic [4:0] a, logic [4:0] b,
                                 logic t, logic q, logic y);
        stim_t r;
        r.start = s; r.mr = m; r.rd = d; r.rs1 = a; r.rs2 = b; r.br = t; r.req = q; r.rdy = y;
        return r;
    endfunction

    function automatic exp_t ex(logic [6:0] c, logic [1:0] s);
        exp_t r;
        r.ctrl = c; r.st = s;
        return r;
    endfunction

    task automatic apply(input stim_t s);
        start = s.start; mem_read = s.mr; rd = s.rd; rs1 = s.rs1; rs2 = s.rs2;
        br_taken = s.br; mem_req = s.req; mem_rdy = s.rdy;
    endtask

    // Leaves the DUT in RUN with zeroed counters, one tick after an edge.
    task automatic do_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        rst_n = 1'b0;
        #2;
        checks++;
        if (state !== 2'd0 || cyc_cnt !== 0 || stl_cnt !== 0 || fl_cnt !== 0 || err !== 1'b0) begin
            errors++;
            $display("FAIL reset_regs: state=%0d cyc=%0d stall=%0d flush=%0d err=%b, want all 0",
                     state, cyc_cnt, stl_cnt, fl_cnt, err);
        end
        checks++;
        if (ctrl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_ctrl: ctrl=%b want %b", ctrl, C_IDLE);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        start = 1'b1;
        @(posedge clk); #1;
        sb.push_back(ex(C_NORM, 2'd1));
        @(negedge clk);
        begin
            exp_t e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL start_run: state=%0d ctrl=%b want state=%0d ctrl=%b", state, ctrl, e.st, e.ctrl);
            end
        end
    endtask

    task automatic test_load_use();
        stim_t s[$];
        exp_t  x[$];
        do_reset();
        s.push_back(mk(1, 1, 5, 0, 5, 0, 0, 0)); x.push_back(ex(C_LU,   1));
        s.push_back(mk(1, 0, 5, 0, 5, 0, 0, 0)); x.push_back(ex(C_NORM, 1));
        s.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0)); x.push_back(ex(C_NORM, 1));
        s.push_back(mk(1, 1, 7, 7, 2, 0, 0, 0)); x.push_back(ex(C_LU,   1));
        foreach (s[i]) begin
            exp_t e;
            apply(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL load_use[%0d]: state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, e.st, e.ctrl);
            end
            if (i == 1) begin
                @(posedge clk); #1;
                checks++;
                if (stl_cnt !== 1) begin
                    errors++;
                    $display("FAIL load_use_stall1: stall=%0d want 1", stl_cnt);
                end
            end else begin
                @(posedge clk); #1;
            end
        end
        checks++;
        if (cyc_cnt !== 4 || stl_cnt !== 2 || fl_cnt !== 0) begin
            errors++;
            $display("FAIL load_use_cnt: cyc=%0d stall=%0d flush=%0d want 4/2/0", cyc_cnt, stl_cnt, fl_cnt);
        end
    endtask

    task automatic test_branch_vs_load_use();
        stim_t s[$];
        exp_t  x[$];
        do_reset();
        s.push_back(mk(1, 1, 3, 3, 0, 1, 0, 0)); x.push_back(ex(C_LU,   1));
        s.push_back(mk(1, 0, 3, 3, 0, 1, 0, 0)); x.push_back(ex(C_BR,   1));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(C_NORM, 1));
        foreach (s[i]) begin
            exp_t e;
            apply(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL branch[%0d]: state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cyc_cnt !== 3 || stl_cnt !== 1 || fl_cnt !== 1) begin
            errors++;
            $display("FAIL branch_cnt: cyc=%0d stall=%0d flush=%0d want 3/1/1", cyc_cnt, stl_cnt, fl_cnt);
        end
    endtask

    task automatic test_mem_wait();
        stim_t s[$];
        exp_t  x[$];
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0)); x.push_back(ex(C_FZ,   1));
        s.push_back(mk(1, 1, 4, 4, 0, 1, 1, 0)); x.push_back(ex(C_FZ,   2));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0)); x.push_back(ex(C_FZ,   2));
        s.push_back(mk(1, 0, 0, 0, 0, 1, 1, 1)); x.push_back(ex(C_BR,   2));
        s.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(C_NORM, 1));
        foreach (s[i]) begin
            exp_t e;
            apply(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL mem_wait[%0d]: state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cyc_cnt !== 5 || stl_cnt !== 3 || fl_cnt !== 1 || err !== 1'b0) begin
            errors++;
            $display("FAIL mem_wait_cnt: cyc=%0d stall=%0d flush=%0d err=%b want 5/3/1/0",
                     cyc_cnt, stl_cnt, fl_cnt, err);
        end
    endtask

    task automatic test_ready_same_cycle_and_idle();
        stim_t s[$];
        exp_t  x[$];
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1)); x.push_back(ex(C_NORM, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0)); x.push_back(ex(C_NORM, 1));
        s.push_back(mk(0, 0, 0, 0, 0, 1, 0, 0)); x.push_back(ex(C_IDLE, 0));
        s.push_back(mk(0, 1, 2, 2, 2, 0, 1, 0)); x.push_back(ex(C_IDLE, 0));
        foreach (s[i]) begin
            exp_t e;
            apply(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL ready_idle[%0d]: state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, e.st, e.ctrl);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cyc_cnt !== 2 || stl_cnt !== 0 || fl_cnt !== 0) begin
            errors++;
            $display("FAIL ready_idle_cnt: cyc=%0d stall=%0d flush=%0d want 2/0/0", cyc_cnt, stl_cnt, fl_cnt);
        end
    endtask

    task automatic test_watchdog();
        stim_t s[$];
        exp_t  x[$];
        do_reset();
        s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0)); x.push_back(ex(C_FZ, 1));
        for (int k = 0; k < 4; k++) begin
            s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0)); x.push_back(ex(C_FZ, 2));
        end
        s.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1)); x.push_back(ex(C_HALT, 3));
        s.push_back(mk(1, 1, 1, 1, 1, 1, 0, 0)); x.push_back(ex(C_HALT, 3));
        foreach (s[i]) begin
            exp_t e;
            apply(s[i]);
            sb.push_back(x[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL watchdog[%0d]: state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, e.st, e.ctrl);
            end
            checks++;
            if (err !== (i >= 5)) begin
                errors++;
                $display("FAIL watchdog_err[%0d]: err=%b want %b", i, err, (i >= 5));
            end
            @(posedge clk); #1;
        end
        checks++;
        if (cyc_cnt !== 5 || stl_cnt !== 5 || err !== 1'b1) begin
            errors++;
            $display("FAIL halt_cnt: cyc=%0d stall=%0d err=%b want 5/5/1", cyc_cnt, stl_cnt, err);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== 2'd0 || err !== 1'b0 || ctrl !== C_IDLE || cyc_cnt !== 0) begin
            errors++;
            $display("FAIL halt_reset: state=%0d err=%b ctrl=%b cyc=%0d want 0/0/%b/0",
                     state, err, ctrl, cyc_cnt, C_IDLE);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 20; i++) begin
            exp_t e;
            apply(mk(1, 1, 6, 6, 6, 0, 0, 0));
            sb.push_back(ex(C_LU, 1));
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (state !== e.st || ctrl !== e.ctrl) begin
                errors++;
                $display("FAIL sat_ctrl[%0d]: state=%0d ctrl=%b want state=%0d ctrl=%b", i, state, ctrl, e.st, e.ctrl);
            end
            @(posedge clk); #1;
            if (i == 13) begin
                checks++;
                if (cyc_cnt !== 14) begin
                    errors++;
                    $display("FAIL sat_pre: cyc=%0d want 14", cyc_cnt);
                end
            end
        end
        checks++;
        if (cyc_cnt !== 15 || stl_cnt !== 15 || fl_cnt !== 0) begin
            errors++;
            $display("FAIL saturation: cyc=%0d stall=%0d flush=%0d want 15/15/0", cyc_cnt, stl_cnt, fl_cnt);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 0));
        test_reset();
        test_load_use();
        test_branch_vs_load_use();
        test_mem_wait();
        test_ready_same_cycle_and_idle();
        test_watchdog();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
